// File: rtl/gbh_pkg.sv
// gbh_pkg: shared defaults, resolve classification and history shift helper
package gbh_pkg;
  localparam int HIST_W_DEF = 4;
  localparam int DEPTH_DEF = 4;
  localparam int HIST_MAX = 16;
  typedef enum logic [1:0] {
    RES_NONE,
    RES_HIT,
    RES_MISS,
    RES_EMPTY
  } res_kind_e;
  // Newest bit enters the LSB; callers keep only their low HIST_W bits.
  function automatic logic [HIST_MAX-1:0] shift_hist(input logic [HIST_MAX-1:0] h, input logic b);
    return {h[HIST_MAX-2:0], b};
  endfunction
endpackage

// File: rtl/gbh_pred_fifo.sv
// gbh_pred_fifo: 1-bit in-order circular FIFO of predicted directions
module gbh_pred_fifo import gbh_pkg::*; #(
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   push_i,
  input  logic                   din_i,
  input  logic                   pop_i,
  input  logic                   clr_i,
  output logic                   dout_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   not_full_o
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);
  logic [DEPTH-1:0] mem_q;
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [PW:0] cnt_q, cnt_d;
  logic nf_q;
  always_comb begin
    cnt_d = clr_i ? '0 : cnt_q + (PW+1)'(push_i) - (PW+1)'(pop_i);
    wr_d = clr_i ? '0 : push_i ? wr_q + PW'(1) : wr_q;
    rd_d = clr_i ? '0 : pop_i ? rd_q + PW'(1) : rd_q;
  end
  // Ready is registered from the next count so it never depends on inputs combinationally.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
      nf_q <= 1'b1;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
      nf_q <= cnt_d != FULL;
    end
  end
  always_ff @(posedge clk_i) begin
    if (push_i && !clr_i) mem_q[wr_q] <= din_i;
  end
  assign dout_o = mem_q[rd_q];
  assign count_o = cnt_q;
  assign not_full_o = nf_q;
endmodule

// File: rtl/gbh_spec.sv
// gbh_spec: speculative/committed global branch history with mispredict recovery
module gbh_spec import gbh_pkg::*; #(
  parameter int HIST_W = HIST_W_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                   CLOCK,
  input  logic                   INIT,
  input  logic                   PRED_VALID,
  input  logic                   PRED_TAKEN,
  output logic                   PRED_READY,
  input  logic                   FLUSH,
  input  logic                   RES_VALID,
  input  logic                   RES_OUTCOME,
  output logic [HIST_W-1:0]      column,
  output logic [HIST_W-1:0]      COMMIT_HIST,
  output logic                   MISPRED,
  output logic [$clog2(DEPTH):0] OCCUPANCY,
  output logic                   RES_ERR
);
  logic [HIST_W-1:0] col_q, col_d, com_q, com_d;
  logic [HIST_MAX-1:0] col_sh, com_sh;
  logic mis_q, mis_d, err_q, err_d;
  logic head, ready, accept, miss, res_ok;
  logic [$clog2(DEPTH):0] occ;
  res_kind_e kind;
  gbh_pred_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i(CLOCK),
    .rst_ni(INIT),
    .push_i(accept),
    .din_i(PRED_TAKEN),
    .pop_i(res_ok),
    .clr_i(FLUSH | miss),
    .dout_o(head),
    .count_o(occ),
    .not_full_o(ready)
  );
  always_comb begin
    kind = !RES_VALID ? RES_NONE : (occ == '0) ? RES_EMPTY : (RES_OUTCOME != head) ? RES_MISS : RES_HIT;
    res_ok = (kind == RES_HIT) || (kind == RES_MISS);
    miss = kind == RES_MISS;
    // A prediction alongside a mispredict is wrong-path and dropped.
    accept = PRED_VALID & ready & ~FLUSH & ~miss;
    col_sh = shift_hist(HIST_MAX'(col_q), PRED_TAKEN);
    com_sh = shift_hist(HIST_MAX'(com_q), RES_OUTCOME);
    com_d = res_ok ? com_sh[HIST_W-1:0] : com_q;
    col_d = (FLUSH | miss) ? com_d : accept ? col_sh[HIST_W-1:0] : col_q;
    mis_d = miss & ~FLUSH;
    err_d = err_q | (kind == RES_EMPTY);
  end
  always_ff @(posedge CLOCK) begin
    if (!INIT) begin
      col_q <= '0;
      com_q <= '0;
      mis_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      col_q <= col_d;
      com_q <= com_d;
      mis_q <= mis_d;
      err_q <= err_d;
    end
  end
  assign column = col_q;
  assign COMMIT_HIST = com_q;
  assign MISPRED = mis_q;
  assign RES_ERR = err_q;
  assign OCCUPANCY = occ;
  assign PRED_READY = ready;
endmodule

// File: tb/tb_gbh_spec.sv
// tb_gbh_spec: directed scenario tests for gbh_spec with HIST_W=4, DEPTH=4
module tb_gbh_spec;
  logic CLOCK = 1'b0;
  logic INIT, PRED_VALID, PRED_TAKEN, FLUSH, RES_VALID, RES_OUTCOME;
  logic PRED_READY, MISPRED, RES_ERR;
  logic [3:0] column, COMMIT_HIST;
  logic [2:0] OCCUPANCY;
  int tests = 0;
  int fails = 0;
  gbh_spec #(.HIST_W(4), .DEPTH(4)) dut (
    .CLOCK(CLOCK), .INIT(INIT), .PRED_VALID(PRED_VALID), .PRED_TAKEN(PRED_TAKEN),
    .PRED_READY(PRED_READY), .FLUSH(FLUSH), .RES_VALID(RES_VALID), .RES_OUTCOME(RES_OUTCOME),
    .column(column), .COMMIT_HIST(COMMIT_HIST), .MISPRED(MISPRED), .OCCUPANCY(OCCUPANCY),
    .RES_ERR(RES_ERR)
  );
  always #5 CLOCK = ~CLOCK;
  task automatic step();
    @(posedge CLOCK);
    #1;
  endtask
  task automatic idle();
    PRED_VALID = 0; PRED_TAKEN = 0; FLUSH = 0; RES_VALID = 0; RES_OUTCOME = 0;
  endtask
  task automatic do_reset();
    idle(); INIT = 0; step(); INIT = 1;
  endtask
  task automatic predict(input logic t);
    idle(); PRED_VALID = 1; PRED_TAKEN = t; step(); idle();
  endtask
  task automatic test_reset();
    do_reset();
    tests++; if (column !== 4'b0000) begin fails++; $display("FAIL reset_column got %b exp 0000", column); end
    tests++; if (COMMIT_HIST !== 4'b0000) begin fails++; $display("FAIL reset_commit got %b exp 0000", COMMIT_HIST); end
    tests++; if (OCCUPANCY !== 3'd0) begin fails++; $display("FAIL reset_occ got %0d exp 0", OCCUPANCY); end
    tests++; if (PRED_READY !== 1'b1) begin fails++; $display("FAIL reset_ready got %b exp 1", PRED_READY); end
    tests++; if (MISPRED !== 1'b0 || RES_ERR !== 1'b0) begin fails++; $display("FAIL reset_flags got mis=%b err=%b exp 0 0", MISPRED, RES_ERR); end
  endtask
  task automatic test_fill();
    predict(1); predict(1); predict(0); predict(1);
    tests++; if (column !== 4'b1101) begin fails++; $display("FAIL fill_column got %b exp 1101", column); end
    tests++; if (OCCUPANCY !== 3'd4) begin fails++; $display("FAIL fill_occ got %0d exp 4", OCCUPANCY); end
    tests++; if (PRED_READY !== 1'b0) begin fails++; $display("FAIL fill_ready got %b exp 0", PRED_READY); end
    predict(0);
    tests++; if (column !== 4'b1101 || OCCUPANCY !== 3'd4) begin fails++; $display("FAIL fill_ignored got col=%b occ=%0d exp 1101 4", column, OCCUPANCY); end
  endtask
  task automatic test_drain();
    logic [3:0] outs;
    logic seen;
    outs = 4'b1011;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      idle(); RES_VALID = 1; RES_OUTCOME = outs[i]; step(); idle();
      seen = seen | MISPRED;
    end
    step(); seen = seen | MISPRED;
    tests++; if (seen !== 1'b0) begin fails++; $display("FAIL drain_mispred got %b exp 0", seen); end
    tests++; if (COMMIT_HIST !== 4'b1101) begin fails++; $display("FAIL drain_commit got %b exp 1101", COMMIT_HIST); end
    tests++; if (OCCUPANCY !== 3'd0 || PRED_READY !== 1'b1) begin fails++; $display("FAIL drain_occ got occ=%0d rdy=%b exp 0 1", OCCUPANCY, PRED_READY); end
    tests++; if (column !== 4'b1101) begin fails++; $display("FAIL drain_column got %b exp 1101", column); end
  endtask
  task automatic test_mispredict();
    do_reset();
    predict(1); predict(1); predict(1);
    tests++; if (column !== 4'b0111 || OCCUPANCY !== 3'd3) begin fails++; $display("FAIL mp_setup got col=%b occ=%0d exp 0111 3", column, OCCUPANCY); end
    idle(); RES_VALID = 1; RES_OUTCOME = 0; step(); idle();
    tests++; if (MISPRED !== 1'b1) begin fails++; $display("FAIL mp_pulse got %b exp 1", MISPRED); end
    tests++; if (COMMIT_HIST !== 4'b0000 || column !== 4'b0000) begin fails++; $display("FAIL mp_hist got com=%b col=%b exp 0000 0000", COMMIT_HIST, column); end
    tests++; if (OCCUPANCY !== 3'd0) begin fails++; $display("FAIL mp_occ got %0d exp 0", OCCUPANCY); end
    step();
    tests++; if (MISPRED !== 1'b0) begin fails++; $display("FAIL mp_one_cycle got %b exp 0", MISPRED); end
  endtask
  task automatic test_simultaneous();
    do_reset();
    predict(1); predict(0);
    idle(); PRED_VALID = 1; PRED_TAKEN = 1; RES_VALID = 1; RES_OUTCOME = 1; step(); idle();
    tests++; if (OCCUPANCY !== 3'd2 || column !== 4'b0101) begin fails++; $display("FAIL sim_ok got occ=%0d col=%b exp 2 0101", OCCUPANCY, column); end
    tests++; if (COMMIT_HIST !== 4'b0001 || MISPRED !== 1'b0) begin fails++; $display("FAIL sim_ok_commit got com=%b mis=%b exp 0001 0", COMMIT_HIST, MISPRED); end
    idle(); PRED_VALID = 1; PRED_TAKEN = 1; RES_VALID = 1; RES_OUTCOME = 1; step(); idle();
    tests++; if (OCCUPANCY !== 3'd0 || MISPRED !== 1'b1) begin fails++; $display("FAIL sim_miss got occ=%0d mis=%b exp 0 1", OCCUPANCY, MISPRED); end
    tests++; if (column !== 4'b0011 || COMMIT_HIST !== 4'b0011) begin fails++; $display("FAIL sim_miss_hist got col=%b com=%b exp 0011 0011", column, COMMIT_HIST); end
  endtask
  task automatic test_flush_err();
    do_reset();
    predict(1); predict(0);
    idle(); FLUSH = 1; PRED_VALID = 1; PRED_TAKEN = 1; step(); idle();
    tests++; if (column !== 4'b0000 || COMMIT_HIST !== 4'b0000) begin fails++; $display("FAIL flush_hist got col=%b com=%b exp 0000 0000", column, COMMIT_HIST); end
    tests++; if (OCCUPANCY !== 3'd0 || MISPRED !== 1'b0) begin fails++; $display("FAIL flush_occ got occ=%0d mis=%b exp 0 0", OCCUPANCY, MISPRED); end
    idle(); RES_VALID = 1; RES_OUTCOME = 1; step(); idle();
    tests++; if (RES_ERR !== 1'b1 || MISPRED !== 1'b0 || COMMIT_HIST !== 4'b0000) begin fails++; $display("FAIL res_err got err=%b mis=%b com=%b exp 1 0 0000", RES_ERR, MISPRED, COMMIT_HIST); end
    predict(1);
    idle(); FLUSH = 1; RES_VALID = 1; RES_OUTCOME = 1; PRED_VALID = 1; PRED_TAKEN = 0; step(); idle();
    tests++; if (COMMIT_HIST !== 4'b0001 || column !== 4'b0001 || OCCUPANCY !== 3'd0) begin fails++; $display("FAIL flush_res got com=%b col=%b occ=%0d exp 0001 0001 0", COMMIT_HIST, column, OCCUPANCY); end
    step(); step();
    tests++; if (RES_ERR !== 1'b1) begin fails++; $display("FAIL res_err_sticky got %b exp 1", RES_ERR); end
    do_reset();
    tests++; if (RES_ERR !== 1'b0) begin fails++; $display("FAIL res_err_clear got %b exp 0", RES_ERR); end
  endtask
  task automatic test_mid_reset();
    logic seen;
    predict(1); predict(1); predict(0);
    tests++; if (OCCUPANCY !== 3'd3 || column !== 4'b0110) begin fails++; $display("FAIL mr_setup got occ=%0d col=%b exp 3 0110", OCCUPANCY, column); end
    INIT = 0; FLUSH = 1; PRED_VALID = 1; PRED_TAKEN = 1; RES_VALID = 1; RES_OUTCOME = 0;
    step(); INIT = 1; idle();
    seen = MISPRED;
    tests++; if (column !== 4'b0000 || COMMIT_HIST !== 4'b0000 || OCCUPANCY !== 3'd0) begin fails++; $display("FAIL mr_state got col=%b com=%b occ=%0d exp 0000 0000 0", column, COMMIT_HIST, OCCUPANCY); end
    tests++; if (PRED_READY !== 1'b1 || RES_ERR !== 1'b0) begin fails++; $display("FAIL mr_flags got rdy=%b err=%b exp 1 0", PRED_READY, RES_ERR); end
    step(); seen = seen | MISPRED;
    tests++; if (seen !== 1'b0) begin fails++; $display("FAIL mr_mispred got %b exp 0", seen); end
  endtask
  initial begin
    INIT = 1;
    idle();
    test_reset();
    test_fill();
    test_drain();
    test_mispredict();
    test_simultaneous();
    test_flush_err();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/gbh_spec.md
GBH_SPEC -- requirements
Module: gbh_spec

Interface
REQ-001 Parameter HIST_W, default 4: history length in bits, legal range 2..16.
REQ-002 Parameter DEPTH, default 4: maximum in-flight unresolved branches, power of two, legal range 2..16.
REQ-003 CLOCK  input  1  single clock; all state updates on rising edge.
REQ-004 INIT  input  1  synchronous, active-low reset.
REQ-005 PRED_VALID  input  1  fetch predicts a conditional branch this cycle.
REQ-006 PRED_TAKEN  input  1  predicted direction; 1 = taken.
REQ-007 PRED_READY  output  1  a prediction can be accepted; high when occupancy < DEPTH.
REQ-008 FLUSH  input  1  external pipeline flush (exception/trap).
REQ-009 RES_VALID  input  1  oldest in-flight branch resolves this cycle; resolution is in program order.
REQ-010 RES_OUTCOME  input  1  actual direction of the resolving branch.
REQ-011 column  output  HIST_W  speculative global history, used as the PHT column index.
REQ-012 COMMIT_HIST  output  HIST_W  architectural history of resolved branches only.
REQ-013 MISPRED  output  1  registered one-cycle pulse: the resolved branch's outcome differed from its stored prediction.
REQ-014 OCCUPANCY  output  $clog2(DEPTH)+1  count of in-flight branches.
REQ-015 RES_ERR  output  1  sticky flag: a resolve was presented while the block was empty.

Function
REQ-016 History shift rule SHALL be h_next = {h[HIST_W-2:0], bit}, with the newest bit in the LSB, for both column and COMMIT_HIST.
REQ-017 Accepted prediction (PRED_VALID & PRED_READY, no FLUSH, no mispredict this cycle): column shifts in PRED_TAKEN; PRED_TAKEN is pushed into an in-order prediction FIFO of depth DEPTH; occupancy +1.
REQ-018 PRED_VALID while PRED_READY=0 SHALL be ignored, with no state change; the same-cycle resolve does not free a slot for that prediction.
REQ-019 Resolve with occupancy>0: pop FIFO head; COMMIT_HIST shifts in RES_OUTCOME; occupancy -1.
REQ-020 Mispredict (RES_OUTCOME != popped head): MISPRED=1 on the next cycle.
REQ-021 On mispredict, column SHALL become {COMMIT_HIST[HIST_W-2:0], RES_OUTCOME}.
REQ-022 On mispredict, the FIFO empties and occupancy becomes 0.
REQ-023 Resolve with occupancy=0: ignored except RES_ERR<=1; MISPRED stays 0.
REQ-024 Simultaneous accepted prediction and correct resolve: both take effect; occupancy is unchanged; column shifts in PRED_TAKEN.
REQ-025 Simultaneous prediction and mispredicting resolve: the prediction is discarded as wrong-path; REQ-020..022 apply alone.
REQ-026 FLUSH has priority over predict and resolve: column<=COMMIT_HIST, FIFO emptied, MISPRED<=0.
REQ-027 Under FLUSH, a same-cycle RES_VALID is still committed to COMMIT_HIST, and column then equals the updated COMMIT_HIST.
REQ-028 FIFO pointers SHALL wrap modulo DEPTH; full is occupancy==DEPTH, empty is occupancy==0.
REQ-029 PRED_READY, column, COMMIT_HIST and OCCUPANCY SHALL be driven directly from registers, with no combinational path from any input.

Reset
REQ-030 While INIT=0 at a rising edge: column=0, COMMIT_HIST=0, FIFO pointers=0, OCCUPANCY=0, MISPRED=0, RES_ERR=0, PRED_READY=1 from the following cycle.
REQ-031 Reset mid-operation SHALL discard all in-flight branches with no MISPRED pulse; INIT overrides FLUSH, PRED_VALID and RES_VALID.

Structure
REQ-032 Shared package gbh_pkg SHALL hold the HIST_W/DEPTH defaults and a shift-in-bit history function used by both history registers.
REQ-033 One sub-module, gbh_pred_fifo (1-bit-wide, DEPTH-entry circular FIFO with push/pop/clear and count), SHALL be instantiated; all history logic stays in gbh_spec.

Verification (HIST_W=4, DEPTH=4)
REQ-034 Reset, then predict T,T,N,T with no resolves -> column=4'b1101, OCCUPANCY=4, PRED_READY=0; a fifth PRED_VALID is ignored.
REQ-035 From REQ-034, resolve T,T,N,T correctly -> COMMIT_HIST=4'b1101, OCCUPANCY=0, MISPRED never asserted, column=4'b1101.
REQ-036 Predict T,T,T; resolve first with outcome N -> next cycle MISPRED=1 for exactly one cycle, COMMIT_HIST=4'b0000, column=4'b0000, OCCUPANCY=0.
REQ-037 Occupancy 2, same cycle PRED_VALID(T) plus correct resolve -> OCCUPANCY stays 2, column gains a 1 in the LSB; repeat with a mispredicting resolve -> OCCUPANCY=0 and the prediction is dropped.
REQ-038 Predict T,N then FLUSH -> column=COMMIT_HIST=4'b0000, OCCUPANCY=0; a later RES_VALID with empty block -> RES_ERR=1 and it holds until INIT=0.
REQ-039 Hold INIT=0 for one edge mid-stream with OCCUPANCY=3 -> all outputs return to reset values and no MISPRED pulse occurs.
